// File: rtl/prio_scan_pkg.sv
// Shared types for the priority scan encoder: FSM state encoding.
// No logic; imported by the encoder top.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc_comb.sv
// Highest-set-bit encoder: idx of the top set bit of vec, any = vec nonzero.
// Latency 0 (purely combinational); no handshake, so no backpressure.
// idx is 0 when vec is zero.
module prio_enc_comb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/prio_scan_encoder.sv
// Captures a request vector and emits one beat per set bit, highest index first.
// Latency 1 from capture to first beat; out_ready low holds the beat, en low freezes the block.
// Define PRIO_SCAN_COUNT_EN to add out_cnt, the popcount of the captured vector.
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_last
`ifdef PRIO_SCAN_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0] out_cnt
`endif
);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   rem;
    logic [N-1:0]   rem_nxt;
    logic [W-1:0]   enc_idx;
    logic           enc_any;
    logic           single;
    logic           cap;
    logic           pop;

    prio_enc_comb #(
        .N (N),
        .W (W)
    ) u_enc (
        .vec (rem),
        .idx (enc_idx),
        .any (enc_any)
    );

    // True for zero or exactly one set bit: both make the current beat final.
    assign single = (rem & (rem - N'(1))) == '0;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        in_ready  = en && (state == IDLE);
        out_valid = en && (state == SCAN);
        cap       = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_idx   = '0;
        out_none  = 1'b0;
        out_last  = 1'b0;

        if (out_valid) begin
            out_idx  = enc_idx;
            out_none = !enc_any;
            out_last = single;
        end

        if (cap) begin
            rem_nxt   = in_vec;
            state_nxt = SCAN;
        end

        if (pop) begin
            rem_nxt = rem & ~(N'(1) << enc_idx);
            if (single) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

`ifdef PRIO_SCAN_COUNT_EN
    localparam int CW = $clog2(N+1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nxt = cnt_nxt + CW'(in_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cap) begin
            cnt_q <= cnt_nxt;
        end
    end

    assign out_cnt = en ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed bench for prio_scan_encoder (N=8): beat order, backpressure, enable freeze, reset abort.
// Expected values are hand-computed constants per vector.
module tb_prio_scan_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_none;
    logic       out_last;
`ifdef PRIO_SCAN_COUNT_EN
    logic [3:0] out_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    prio_scan_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last)
`ifdef PRIO_SCAN_COUNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".ready"}, int'(in_ready), 1);
        chk({tag, ".idx"},   int'(out_idx), 0);
        chk({tag, ".none"},  int'(out_none), 0);
        chk({tag, ".last"},  int'(out_last), 0);
    endtask

    task automatic send(input string tag, input logic [7:0] v);
        chk({tag, ".cap_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_vec   = v;
        cyc();
        in_valid = 1'b0;
        in_vec   = 8'h00;
    endtask

    // Check the current beat, then let the edge (and any handshake) happen.
    task automatic beat(input string tag, input int idx, input int none, input int last);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".ready"}, int'(in_ready), 0);
        chk({tag, ".idx"},   int'(out_idx), idx);
        chk({tag, ".none"},  int'(out_none), none);
        chk({tag, ".last"},  int'(out_last), last);
        cyc();
    endtask

    initial begin
        int exp_idx;
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_idle("reset");
`ifdef PRIO_SCAN_COUNT_EN
        chk("reset.cnt", int'(out_cnt), 0);
`endif

        // en low while idle: in_ready must drop
        en = 1'b0;
        #1;
        chk("idle_en0.ready", int'(in_ready), 0);
        en = 1'b1;
        #1;

        // 1010_0100: beats 7,5,2
        send("a4", 8'hA4);
`ifdef PRIO_SCAN_COUNT_EN
        chk("a4.cnt0", int'(out_cnt), 3);
`endif
        beat("a4.b7", 7, 0, 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("a4.cnt1", int'(out_cnt), 3);
`endif
        beat("a4.b5", 5, 0, 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("a4.cnt2", int'(out_cnt), 3);
`endif
        beat("a4.b2", 2, 0, 1);
        chk_idle("a4.after");

        // all-zero vector: one beat with none set
        send("z", 8'h00);
        beat("z.b0", 0, 1, 1);
        chk_idle("z.after");

        // 0x81 with backpressure on the first beat
        send("81", 8'h81);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("81.hold%0d", i), 7, 0, 0);
        end
        out_ready = 1'b1;
        beat("81.b7", 7, 0, 0);
        beat("81.b0", 0, 0, 1);
        chk_idle("81.after");

        // 0xFF with en low for two cycles after the third beat
        send("ff", 8'hFF);
        for (int i = 0; i < 3; i++) begin
            exp_idx = 7 - i;
            beat($sformatf("ff.b%0d", exp_idx), exp_idx, 0, 0);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("ff.frz%0d.valid", i), int'(out_valid), 0);
            chk($sformatf("ff.frz%0d.ready", i), int'(in_ready), 0);
            chk($sformatf("ff.frz%0d.idx", i),   int'(out_idx), 0);
            chk($sformatf("ff.frz%0d.last", i),  int'(out_last), 0);
`ifdef PRIO_SCAN_COUNT_EN
            chk($sformatf("ff.frz%0d.cnt", i),   int'(out_cnt), 0);
`endif
            cyc();
        end
        en = 1'b1;
        #1;
        for (int i = 4; i >= 0; i--) begin
            beat($sformatf("ff.b%0d", i), i, 0, (i == 0) ? 1 : 0);
        end
        chk_idle("ff.after");

        // 0xF0 aborted by reset after the first beat
        send("f0", 8'hF0);
        beat("f0.b7", 7, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle("f0.rst");
        cyc();
        chk_idle("f0.rst2");
        send("01", 8'h01);
        beat("01.b0", 0, 0, 1);
        chk_idle("01.after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
